// File: rtl/stream_frame_ctrl_if.sv
// Signal bundle shared by the byte streamer, the frame controller and the payload consumer.
// slave is the controller's view; master is the surrounding environment's view.
interface stream_frame_ctrl_if;
    logic       enable;
    logic       bit_strobe;
    logic       shift_enable;
    logic [7:0] rx_byte;
    logic       rx_byte_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    modport slave (
        input  enable, bit_strobe, rx_byte, rx_byte_ready, out_ready,
        output shift_enable, out_data, out_valid, out_last,
        frame_done, frame_err, err_code, busy
    );

    modport master (
        output enable, bit_strobe, rx_byte, rx_byte_ready, out_ready,
        input  shift_enable, out_data, out_valid, out_last,
        frame_done, frame_err, err_code, busy
    );
endinterface

// File: rtl/stream_frame_ctrl.sv
// Frame parser for the serial-to-parallel streamer: SYNC, LEN, LEN payload bytes, CSUM.
// Payload is cut through a small FIFO to a valid/ready consumer, tagged with end-of-frame.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   S_HUNT    | waiting for SYNC_BYTE, all other bytes ignored
//   S_LEN     | next byte is the payload length
//   S_PAYLOAD | forwarding payload bytes into the FIFO
//   S_CSUM    | next byte closes the frame (sum of LEN+payload+CSUM == 0)
module stream_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         MAX_LEN    = 16,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    stream_frame_ctrl_if.slave sfc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_LEN     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CSUM    = 2'd3
    } state_t;

    state_t         r_state;
    logic [7:0]     r_cnt;
    logic [7:0]     r_csum;
    logic           r_frame_done;
    logic           r_frame_err;
    logic [1:0]     r_err_code;

    logic [7:0]     r_mem_data [FIFO_DEPTH];
    logic           r_mem_last [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic           w_valid;
    logic           w_pop;
    logic           w_byte;
    logic           w_room;
    logic           w_push;
    logic [7:0]     w_sum;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && sfc.out_ready;
    assign w_byte  = sfc.enable && sfc.rx_byte_ready;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_room  = (r_count < CW'(FIFO_DEPTH)) || w_pop;
    assign w_push  = w_byte && (r_state == S_PAYLOAD) && w_room;
    assign w_sum   = r_csum + sfc.rx_byte;

    assign sfc.shift_enable = sfc.enable && sfc.bit_strobe;
    assign sfc.out_valid    = w_valid;
    assign sfc.out_data     = w_valid ? r_mem_data[r_rd_ptr] : 8'h00;
    assign sfc.out_last     = w_valid ? r_mem_last[r_rd_ptr] : 1'b0;
    assign sfc.frame_done   = r_frame_done;
    assign sfc.frame_err    = r_frame_err;
    assign sfc.err_code     = r_err_code;
    assign sfc.busy         = (r_state != S_HUNT);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= sfc.rx_byte;
            r_mem_last[r_wr_ptr] <= (r_cnt == 8'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_HUNT;
            r_cnt        <= 8'h00;
            r_csum       <= 8'h00;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_code   <= 2'b00;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            // Dropping enable abandons the frame; the FIFO keeps what it already holds.
            if (!sfc.enable) begin
                r_state <= S_HUNT;
            end else if (sfc.rx_byte_ready) begin
                case (r_state)
                    S_HUNT: begin
                        if (sfc.rx_byte == SYNC_BYTE) r_state <= S_LEN;
                    end
                    S_LEN: begin
                        r_cnt  <= sfc.rx_byte;
                        r_csum <= sfc.rx_byte;
                        if (sfc.rx_byte > 8'(MAX_LEN)) begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= 2'b01;
                            r_state     <= S_HUNT;
                        end else if (sfc.rx_byte == 8'h00) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        if (w_room) begin
                            r_csum <= w_sum;
                            r_cnt  <= r_cnt - 8'd1;
                            if (r_cnt == 8'd1) r_state <= S_CSUM;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= 2'b11;
                            r_state     <= S_HUNT;
                        end
                    end
                    S_CSUM: begin
                        if (w_sum == 8'h00) begin
                            r_frame_done <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= 2'b10;
                        end
                        r_state <= S_HUNT;
                    end
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_frame_ctrl.sv
// Randomised frame traffic against a queue-based frame model; a negedge monitor
// pops expected payload bytes and frame outcomes as the controller presents them.
module tb_stream_frame_ctrl;
    localparam logic [7:0] SYNC  = 8'hA5;
    localparam int         MAXL  = 16;
    localparam int         DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_frame_ctrl_if bus ();

    stream_frame_ctrl #(
        .SYNC_BYTE (SYNC),
        .MAX_LEN   (MAXL),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sfc(bus)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } pl_t;
    typedef struct {
        int unsigned stamp;
        bit          is_err;
        logic [1:0]  code;
    } ev_t;

    pl_t        exp_q[$];
    ev_t        evt_q[$];
    logic [7:0] sq[$];

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    // frame model: position within the frame rather than a state code
    bit         m_in_frame = 0;
    bit         m_need_len = 0;
    int         m_rem = 0;
    int         m_sum = 0;
    int         m_occ_now = 0, m_occ_next = 0;
    bit         m_busy_now = 0, m_busy_next = 0;
    logic [1:0] m_err_now = 2'b00, m_err_next = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_chk++;
        n_fail++;
        $display("FAIL %s: actual %s (cycle %0d)", name, what, cyc);
    endtask

    task automatic post_event(input bit is_err, input logic [1:0] code);
        ev_t e;
        e.stamp  = cyc + 1;
        e.is_err = is_err;
        e.code   = code;
        evt_q.push_back(e);
        if (is_err) m_err_next = code;
    endtask

    // Predicts the effect of the coming clock edge given the inputs just driven.
    task automatic model_step(input bit rb, input logic [7:0] b, input bit en, input bit ordy);
        bit  pop, push;
        pl_t p;
        m_occ_now  = m_occ_next;
        m_busy_now = m_busy_next;
        m_err_now  = m_err_next;
        pop  = (m_occ_now > 0) && ordy;
        push = 0;
        if (!en) begin
            m_in_frame = 0;
        end else if (rb) begin
            if (!m_in_frame) begin
                if (b == SYNC) begin
                    m_in_frame = 1;
                    m_need_len = 1;
                end
            end else if (m_need_len) begin
                m_need_len = 0;
                m_sum      = b;
                if (b > MAXL) begin
                    post_event(1, 2'b01);
                    m_in_frame = 0;
                end else begin
                    m_rem = b;
                end
            end else if (m_rem > 0) begin
                if (m_occ_now < DEPTH || pop) begin
                    p.d = b;
                    p.l = (m_rem == 1);
                    exp_q.push_back(p);
                    push  = 1;
                    m_sum = (m_sum + b) % 256;
                    m_rem--;
                end else begin
                    post_event(1, 2'b11);
                    m_in_frame = 0;
                end
            end else begin
                if ((m_sum + b) % 256 == 0) post_event(0, 2'b00);
                else                        post_event(1, 2'b10);
                m_in_frame = 0;
            end
        end
        m_occ_next  = m_occ_now + (push ? 1 : 0) - (pop ? 1 : 0);
        m_busy_next = m_in_frame;
    endtask

    task automatic drive_cycle(input bit rb, input logic [7:0] b, input bit en, input bit ordy);
        @(posedge clk);
        #1;
        bus.rx_byte_ready = rb;
        bus.rx_byte       = b;
        bus.enable        = en;
        bus.out_ready     = ordy;
        bus.bit_strobe    = 1'($urandom_range(0, 1));
        model_step(rb, b, en, ordy);
    endtask

    task automatic run_stream(input int pb, input int pr, input int pe);
        int guard = 0;
        while (sq.size() > 0 && guard < 5000) begin
            bit         rb, en, ordy;
            logic [7:0] b;
            rb   = ($urandom_range(0, 99) < pb);
            en   = !($urandom_range(0, 99) < pe);
            ordy = ($urandom_range(0, 99) < pr);
            b    = rb ? sq.pop_front() : 8'($urandom);
            drive_cycle(rb, b, en, ordy);
            guard++;
        end
        if (sq.size() > 0) fail_now("stream_timeout", "bytes left unsent");
    endtask

    task automatic drain();
        int guard = 0;
        while ((m_occ_next > 0 || evt_q.size() > 0) && guard < 200) begin
            drive_cycle(0, 8'($urandom), 1, 1);
            guard++;
        end
        if (guard >= 200) fail_now("drain_timeout", "output not drained");
        drive_cycle(0, 8'h00, 1, 1);
        drive_cycle(0, 8'h00, 1, 1);
    endtask

    task automatic send(input logic [7:0] bytes[$], input int pr);
        foreach (bytes[i]) sq.push_back(bytes[i]);
        run_stream(100, pr, 0);
        drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"},  bus.out_valid, 0);
        chk({tag, "_out_data"},   bus.out_data, 0);
        chk({tag, "_out_last"},   bus.out_last, 0);
        chk({tag, "_frame_done"}, bus.frame_done, 0);
        chk({tag, "_frame_err"},  bus.frame_err, 0);
        chk({tag, "_err_code"},   bus.err_code, 0);
        chk({tag, "_busy"},       bus.busy, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        bus.rx_byte_ready = 0;
        bus.out_ready     = 0;
        rst = 1;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        evt_q.delete();
        m_in_frame = 0; m_need_len = 0; m_rem = 0; m_sum = 0;
        m_occ_now = 0; m_occ_next = 0;
        m_busy_now = 0; m_busy_next = 0;
        m_err_now = 2'b00; m_err_next = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic add_frame(input int kind);
        int len, sum;
        logic [7:0] v;
        case (kind)
            0, 1, 2, 3, 4, 7: begin
                len = (kind == 7) ? MAXL : $urandom_range(0, MAXL);
                sq.push_back(SYNC);
                sq.push_back(8'(len));
                sum = len;
                for (int i = 0; i < len; i++) begin
                    v = 8'($urandom);
                    sq.push_back(v);
                    sum += v;
                end
                v = 8'((256 - (sum % 256)) % 256);
                if (kind == 4) v = v + 8'($urandom_range(1, 255));
                sq.push_back(v);
            end
            5: begin
                sq.push_back(SYNC);
                sq.push_back(8'($urandom_range(MAXL + 1, 255)));
                sq.push_back(8'($urandom));
            end
            default: begin
                for (int i = 0; i < $urandom_range(1, 4); i++) sq.push_back(8'($urandom));
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst && started) begin
            pl_t p;
            ev_t e;
            chk("out_valid", bus.out_valid, (m_occ_now > 0));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("out_pop", "unexpected payload byte");
                end else begin
                    p = exp_q.pop_front();
                    chk("out_data", bus.out_data, p.d);
                    chk("out_last", bus.out_last, p.l);
                end
            end
            chk("busy", bus.busy, m_busy_now);
            chk("err_code", bus.err_code, m_err_now);
            chk("shift_enable", bus.shift_enable, bus.enable & bus.bit_strobe);
            while (evt_q.size() > 0 && evt_q[0].stamp < cyc) begin
                e = evt_q.pop_front();
                fail_now("frame_event", e.is_err ? "missing frame_err" : "missing frame_done");
            end
            if (bus.frame_done || bus.frame_err) begin
                if (evt_q.size() == 0) begin
                    fail_now("frame_event", "unexpected frame_done/frame_err");
                end else begin
                    e = evt_q.pop_front();
                    chk("event_kind", bus.frame_err, e.is_err);
                    chk("event_single", bus.frame_done & bus.frame_err, 0);
                    chk("event_time", cyc, e.stamp);
                    if (e.is_err) chk("event_code", bus.err_code, e.code);
                end
            end
        end
    end

    initial begin
        bus.enable        = 1'b1;
        bus.bit_strobe    = 1'b0;
        bus.rx_byte       = 8'h00;
        bus.rx_byte_ready = 1'b0;
        bus.out_ready     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst     = 1'b0;
        started = 1'b1;

        send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}, 100);
        send('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00}, 100);
        send('{8'hA5, 8'h11, 8'hA5, 8'h00, 8'h00}, 100);
        send('{8'hA5, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 0);
        send('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h81}, 100);

        // enable dropped mid-payload, then the tail is parsed as hunt bytes
        drive_cycle(1, 8'hA5, 1, 0);
        drive_cycle(1, 8'h04, 1, 0);
        drive_cycle(1, 8'h01, 1, 0);
        drive_cycle(1, 8'h02, 1, 0);
        drive_cycle(1, 8'h03, 0, 0);
        drive_cycle(0, 8'h00, 1, 0);
        drive_cycle(1, 8'h04, 1, 0);
        drain();

        // reset mid-frame with bytes waiting in the FIFO
        drive_cycle(1, 8'hA5, 1, 0);
        drive_cycle(1, 8'h05, 1, 0);
        drive_cycle(1, 8'h01, 1, 0);
        drive_cycle(1, 8'h02, 1, 0);
        do_reset();
        drive_cycle(0, 8'h00, 1, 1);
        send('{8'hA5, 8'h01, 8'h40, 8'hBF}, 100);

        for (int it = 0; it < 150; it++) begin
            int prs[4];
            prs = '{10, 50, 90, 100};
            add_frame($urandom_range(0, 7));
            if (it % 10 == 9) run_stream($urandom_range(30, 100), 0, 0);
            else run_stream($urandom_range(30, 100), prs[$urandom_range(0, 3)],
                            (it % 7 == 3) ? 5 : 0);
        end
        drain();

        chk("exp_q_empty", exp_q.size(), 0);
        chk("evt_q_empty", evt_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
